// File: rtl/l1_pkg.sv
// Shared types and width helpers for the L1 stream pointer/prefetch controller.
package l1_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2,
      END    = 2'd3
   } l1_state_e;

   function automatic int unsigned clid_w(input int unsigned ncl);
      return $clog2(ncl);
   endfunction

   function automatic int unsigned clofs_w(input int unsigned cl_size);
      return $clog2(cl_size);
   endfunction

   function automatic int unsigned ptr_w(input int unsigned ncl, input int unsigned cl_size);
      return clid_w(ncl) + clofs_w(cl_size);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned ncl, input int unsigned cl_size);
      return ptr_w(ncl, cl_size) + 1;
   endfunction

endpackage

// File: rtl/l1_rd_grant.sv
// Prefix-popcount read grant: port k is ready while the valid count up to k fits in avail.
module l1_rd_grant #(
   parameter int unsigned nports    = 8,
   parameter int unsigned cnt_width = 8
) (
   input  logic                           en_i,
   input  logic [nports-1:0]              rd_v_i,
   input  logic [cnt_width-1:0]           avail_i,
   output logic [nports-1:0]              rd_r_o,
   output logic [$clog2(nports+1)-1:0]    g_o
);

   localparam int unsigned g_width = $clog2(nports + 1);

   logic [cnt_width-1:0] pc;
   logic                 rdy;

   always_comb begin
      pc     = '0;
      rdy    = 1'b0;
      rd_r_o = '0;
      g_o    = '0;
      for (int k = 0; k < int'(nports); k++) begin
         pc        = pc + cnt_width'(rd_v_i[k]);
         rdy       = en_i && (pc <= avail_i);
         rd_r_o[k] = rdy;
         if (rdy && rd_v_i[k]) begin
            g_o = g_o + g_width'(1);
         end
      end
   end

endmodule

// File: rtl/l1_stream_ptr_mc.sv
// Multi-port L1 stream read pointer with cacheline prefetch accounting and
// restart/drain control.
module l1_stream_ptr_mc
   import l1_pkg::*;
#(
   parameter int unsigned nports  = 8,
   parameter int unsigned ncl     = 16,
   parameter int unsigned cl_size = 8,
   parameter int unsigned max_out = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              i_rst_v,
   output logic                              i_rst_r,
   input  logic [clid_w(ncl)-1:0]            i_rst_ea_b,
   input  logic                              i_rst_end,
   output logic                              o_rst_v,
   input  logic                              o_rst_r,
   output logic                              o_rst_end,
   input  logic [nports-1:0]                 i_rd_v,
   output logic [nports-1:0]                 i_rd_r,
   output logic [ptr_w(ncl, cl_size)-1:0]    o_ptr,
   output logic [cnt_w(ncl, cl_size)-1:0]    o_avail,
   output logic                              o_clreq_v,
   input  logic                              o_clreq_r,
   input  logic                              i_clrsp_v,
   output logic                              i_clrsp_r
);

   localparam int unsigned clid_width  = clid_w(ncl);
   localparam int unsigned clofs_width = clofs_w(cl_size);
   localparam int unsigned ptr_width   = ptr_w(ncl, cl_size);
   localparam int unsigned cnt_width   = cnt_w(ncl, cl_size);
   localparam int unsigned fw          = clid_width + 1;
   localparam int unsigned g_width     = $clog2(nports + 1);

   l1_state_e              state_q, state_d;
   logic [ptr_width-1:0]   ptr_q, ptr_d;
   logic [fw-1:0]          filled_q, filled_d;
   logic [fw-1:0]          outst_q, outst_d;
   logic [cnt_width-1:0]   avail_q, avail_d;
   logic                   rst_v_q, rst_v_d;
   logic                   rst_r_q, rst_r_d;
   logic                   rst_end_q, rst_end_d;
   logic                   clreq_v_q, clreq_v_d;
   logic                   clrsp_r_q, clrsp_r_d;

   logic                   rd_en;
   logic [g_width-1:0]     g;
   logic                   req_acc, rsp_acc, rst_acc, line_free;

   assign rd_en = (state_q == ACTIVE) || (state_q == DRAIN);

   l1_rd_grant #(
      .nports    (nports),
      .cnt_width (cnt_width)
   ) u_grant (
      .en_i    (rd_en),
      .rd_v_i  (i_rd_v),
      .avail_i (avail_q),
      .rd_r_o  (i_rd_r),
      .g_o     (g)
   );

   // Request, response and line-free accounting all net out in the same cycle.
   always_comb begin
      state_d   = state_q;
      rst_v_d   = rst_v_q && !o_rst_r;
      req_acc   = clreq_v_q && o_clreq_r;
      rsp_acc   = i_clrsp_v && clrsp_r_q;
      rst_acc   = i_rst_v && rst_r_q;
      line_free = (cnt_width'(ptr_q[clofs_width-1:0]) + cnt_width'(g)) >= cnt_width'(cl_size);
      ptr_d     = ptr_q + ptr_width'(g);
      filled_d  = filled_q + fw'(rsp_acc) - fw'(line_free);
      outst_d   = outst_q + fw'(req_acc) - fw'(rsp_acc);
      avail_d   = (cnt_width'(filled_d) << clofs_width) - cnt_width'(ptr_d[clofs_width-1:0]);

      case (state_q)
         IDLE, END: begin
            if (rst_acc) begin
               state_d  = i_rst_end ? DRAIN : ACTIVE;
               ptr_d    = {i_rst_ea_b, clofs_width'(0)};
               filled_d = '0;
               outst_d  = '0;
               avail_d  = '0;
               rst_v_d  = 1'b1;
            end
         end
         ACTIVE: begin
            if (i_rst_end) state_d = DRAIN;
         end
         DRAIN: begin
            if ((outst_d == '0) && (avail_d == '0)) state_d = END;
         end
         default: state_d = IDLE;
      endcase

      clreq_v_d = (state_d == ACTIVE) && (outst_d < fw'(max_out))
                  && ((filled_d + outst_d) < fw'(ncl));
      clrsp_r_d = (outst_d != '0);
      rst_end_d = (state_d == IDLE) || (state_d == END);
      rst_r_d   = rst_end_d && !rst_v_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         filled_q  <= '0;
         outst_q   <= '0;
         avail_q   <= '0;
         rst_v_q   <= 1'b0;
         rst_r_q   <= 1'b1;
         rst_end_q <= 1'b1;
         clreq_v_q <= 1'b0;
         clrsp_r_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         filled_q  <= filled_d;
         outst_q   <= outst_d;
         avail_q   <= avail_d;
         rst_v_q   <= rst_v_d;
         rst_r_q   <= rst_r_d;
         rst_end_q <= rst_end_d;
         clreq_v_q <= clreq_v_d;
         clrsp_r_q <= clrsp_r_d;
      end
   end

   assign o_ptr     = ptr_q;
   assign o_avail   = avail_q;
   assign o_rst_v   = rst_v_q;
   assign i_rst_r   = rst_r_q;
   assign o_rst_end = rst_end_q;
   assign o_clreq_v = clreq_v_q;
   assign i_clrsp_r = clrsp_r_q;

endmodule

// File: tb/tb_l1_stream_ptr_mc.sv
// Directed bench for l1_stream_ptr_mc with nports=4, ncl=4, cl_size=8, max_out=2.
module tb_l1_stream_ptr_mc;

   logic       clk = 1'b0;
   logic       reset;
   logic       i_rst_v, i_rst_r, i_rst_end;
   logic [1:0] i_rst_ea_b;
   logic       o_rst_v, o_rst_r, o_rst_end;
   logic [3:0] i_rd_v, i_rd_r;
   logic [4:0] o_ptr;
   logic [5:0] o_avail;
   logic       o_clreq_v, o_clreq_r, i_clrsp_v, i_clrsp_r;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   l1_stream_ptr_mc #(
      .nports (4), .ncl (4), .cl_size (8), .max_out (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_rst_v    (i_rst_v),
      .i_rst_r    (i_rst_r),
      .i_rst_ea_b (i_rst_ea_b),
      .i_rst_end  (i_rst_end),
      .o_rst_v    (o_rst_v),
      .o_rst_r    (o_rst_r),
      .o_rst_end  (o_rst_end),
      .i_rd_v     (i_rd_v),
      .i_rd_r     (i_rd_r),
      .o_ptr      (o_ptr),
      .o_avail    (o_avail),
      .o_clreq_v  (o_clreq_v),
      .o_clreq_r  (o_clreq_r),
      .i_clrsp_v  (i_clrsp_v),
      .i_clrsp_r  (i_clrsp_r)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   int exp_ptr[5]   = '{20, 24, 28, 0, 4};
   int exp_avail[5] = '{20, 16, 12, 8, 4};

   initial begin
      reset = 1'b1; i_rst_v = 1'b0; i_rst_ea_b = '0; i_rst_end = 1'b0; o_rst_r = 1'b0;
      i_rd_v = '0; o_clreq_r = 1'b0; i_clrsp_v = 1'b0;
      #3;
      check("rst_end_at_reset", o_rst_end, 1);
      check("avail_at_reset", o_avail, 0);
      check("ptr_at_reset", o_ptr, 0);
      check("clreq_at_reset", o_clreq_v, 0);
      check("clrsp_r_at_reset", i_clrsp_r, 0);
      check("rst_v_at_reset", o_rst_v, 0);
      check("rd_r_at_reset", i_rd_r, 0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check("idle_rst_r", i_rst_r, 1);

      // restart at cacheline 2
      i_rst_v = 1'b1; i_rst_ea_b = 2'd2;
      step();
      i_rst_v = 1'b0;
      check("restart_ptr", o_ptr, 16);
      check("restart_rst_v", o_rst_v, 1);
      check("restart_rst_r", i_rst_r, 0);
      check("restart_rst_end", o_rst_end, 0);
      check("restart_clreq", o_clreq_v, 1);
      check("restart_avail", o_avail, 0);
      o_rst_r = 1'b1; o_clreq_r = 1'b1;
      step();
      check("rst_v_cleared", o_rst_v, 0);
      check("req2_valid", o_clreq_v, 1);
      step();
      check("max_out_stop", o_clreq_v, 0);
      check("clrsp_r_outst", i_clrsp_r, 1);
      step();
      check("no_third_req", o_clreq_v, 0);

      // two responses
      o_clreq_r = 1'b0; i_clrsp_v = 1'b1;
      step();
      check("rsp1_avail", o_avail, 8);
      check("rsp1_clreq", o_clreq_v, 1);
      step();
      check("rsp2_avail", o_avail, 16);
      check("rsp2_clrsp_r", i_clrsp_r, 0);

      // full-width reads
      i_clrsp_v = 1'b0; i_rd_v = 4'b1111;
      #1 check("rd_r_full", i_rd_r, 15);
      step();
      check("rd1_ptr", o_ptr, 20);
      check("rd1_avail", o_avail, 12);
      step();
      check("rd2_ptr", o_ptr, 24);
      check("rd2_avail", o_avail, 8);
      o_clreq_r = 1'b1;
      step();
      check("rd3_ptr", o_ptr, 28);
      check("rd3_avail", o_avail, 4);
      check("rd3_clrsp_r", i_clrsp_r, 1);
      o_clreq_r = 1'b0;
      step();
      check("wrap_ptr", o_ptr, 0);
      check("wrap_avail", o_avail, 0);
      #1 check("rd_r_empty", i_rd_r, 0);

      // refill with overlapping request+response
      i_rd_v = '0; i_clrsp_v = 1'b1; o_clreq_r = 1'b1;
      step();
      check("fill1_avail", o_avail, 8);
      step();
      check("fill2_avail", o_avail, 16);
      step();
      check("fill3_avail", o_avail, 24);
      check("fill_limit_clreq", o_clreq_v, 0);
      i_clrsp_v = 1'b0; i_rd_v = 4'b1111;
      step();
      check("part_ptr", o_ptr, 4);
      check("part_avail", o_avail, 20);
      i_clrsp_v = 1'b1;
      step();
      check("net_rsp_free_avail", o_avail, 24);
      check("net_rsp_free_ptr", o_ptr, 8);
      check("net_rsp_free_clrsp_r", i_clrsp_r, 0);
      check("net_rsp_free_clreq", o_clreq_v, 1);
      step();
      check("rsp_rejected_avail", o_avail, 20);
      check("rsp_rejected_clrsp_r", i_clrsp_r, 1);
      check("req_acc_clreq", o_clreq_v, 0);
      step();
      check("net3_avail", o_avail, 24);
      check("net3_ptr", o_ptr, 16);
      check("net3_clrsp_r", i_clrsp_r, 0);
      check("net3_clreq", o_clreq_v, 1);

      // read down to avail=3
      i_clrsp_v = 1'b0; o_clreq_r = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("drain_ptr%0d", i), o_ptr, exp_ptr[i]);
         check($sformatf("drain_avail%0d", i), o_avail, exp_avail[i]);
      end
      i_rd_v = 4'b0001;
      step();
      check("avail3", o_avail, 3);
      i_rd_v = 4'b1111;
      #1 check("avail3_rd_r", i_rd_r, 7);
      step();
      check("avail3_ptr", o_ptr, 8);
      check("avail3_next_avail", o_avail, 0);

      // end request with two outstanding
      i_rd_v = '0; o_clreq_r = 1'b1;
      step();
      check("pre_end_clreq", o_clreq_v, 1);
      i_rst_end = 1'b1;
      step();
      check("end_clreq_drop", o_clreq_v, 0);
      check("end_rst_end_low", o_rst_end, 0);
      step();
      check("drain_clreq", o_clreq_v, 0);
      check("drain_clrsp_r", i_clrsp_r, 1);
      i_clrsp_v = 1'b1;
      step();
      check("drain_rsp1_avail", o_avail, 8);
      step();
      check("drain_rsp2_avail", o_avail, 16);
      check("drain_rsp2_rst_end", o_rst_end, 0);
      i_clrsp_v = 1'b0; o_clreq_r = 1'b0; i_rd_v = 4'b1111;
      for (int i = 0; i < 3; i++) step();
      check("drain_last_avail", o_avail, 4);
      check("drain_not_end", o_rst_end, 0);
      step();
      check("end_avail", o_avail, 0);
      check("end_rst_end", o_rst_end, 1);
      check("end_rst_r", i_rst_r, 1);
      #1 check("end_rd_r", i_rd_r, 0);

      // restart from END, then async reset mid-ACTIVE
      i_rst_end = 1'b0; i_rst_v = 1'b1; i_rst_ea_b = 2'd1;
      step();
      check("restart2_ptr", o_ptr, 8);
      check("restart2_rst_v", o_rst_v, 1);
      i_rst_v = 1'b0; o_clreq_r = 1'b1;
      step();
      check("restart2_clrsp_r", i_clrsp_r, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_end", o_rst_end, 1);
      check("async_avail", o_avail, 0);
      check("async_ptr", o_ptr, 0);
      check("async_clreq", o_clreq_v, 0);
      check("async_clrsp_r", i_clrsp_r, 0);
      check("async_rst_v", o_rst_v, 0);
      check("async_rd_r", i_rd_r, 0);
      @(negedge clk);
      reset = 1'b0; i_clrsp_v = 1'b1;
      #1 check("post_rst_clrsp_r", i_clrsp_r, 0);
      step();
      check("post_rst_avail", o_avail, 0);
      check("post_rst_rst_end", o_rst_end, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
